// File: rtl/seq_fetch_streamer.sv
// seq_fetch_streamer
//   Reads a contiguous, wrap-around window of the sequence register file.
//   It reads one ASCII base per cycle and converts it to a 2-bit nucleotide
//   code (A=0, C=1, G=2, T=3). Each code goes to the scoring array over a
//   valid/ready handshake. The streamer sustains one beat per cycle while the
//   sink is ready and holds a beat without loss under back-pressure.
//
// Ports
//   clk, rst          system clock; synchronous active-high reset
//   start             1-cycle command pulse, honoured only when idle
//   base_addr, len    command: first entry (mod DEPTH) and base count (clamped to DEPTH)
//   busy, done        command in progress / 1-cycle completion pulse
//   r_addr, r_data    register-file read port (combinational read)
//   m_valid, m_ready  output handshake
//   m_char            raw character
//   m_code            nucleotide code
//   m_invalid         character is not A/C/G/T in either case
//   m_index, m_last   beat position within the command / final beat flag
module seq_fetch_streamer #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 128,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [31:0]           base_addr,
   input  logic [LEN_WIDTH-1:0]  len,
   output logic                  busy,
   output logic                  done,
   output logic [31:0]           r_addr,
   input  logic [31:0]           r_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_char,
   output logic [1:0]            m_code,
   output logic                  m_invalid,
   output logic [LEN_WIDTH-1:0]  m_index,
   output logic                  m_last
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH, S_DONE} state_e;

   state_e                state_q;
   logic [AW-1:0]         rd_ptr_q;
   logic [LEN_WIDTH-1:0]  remaining_q;
   logic [LEN_WIDTH-1:0]  issue_idx_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  m_valid_q;
   logic [DATA_WIDTH-1:0] m_char_q;
   logic [1:0]            m_code_q;
   logic                  m_invalid_q;
   logic [LEN_WIDTH-1:0]  m_index_q;
   logic                  m_last_q;

   logic [DATA_WIDTH-1:0] char_d;
   logic [1:0]            code_d;
   logic                  invalid_d;
   logic [LEN_WIDTH-1:0]  len_clamp_d;
   logic                  load_d;

   // Upper address bits and upper read-data bits are architecturally ignored.
   logic unused_bits;
   assign unused_bits = ^{base_addr[31:AW], r_data[31:DATA_WIDTH]};

   assign char_d      = r_data[DATA_WIDTH-1:0];
   assign len_clamp_d = (len > LEN_WIDTH'(DEPTH)) ? LEN_WIDTH'(DEPTH) : len;
   // The output register may take a new beat when it is empty or its beat
   // is being consumed this cycle.
   assign load_d      = !m_valid_q || m_ready;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case can infer a latch.
      code_d    = 2'd0;
      invalid_d = 1'b0;
      case (char_d)
         DATA_WIDTH'(8'h41), DATA_WIDTH'(8'h61): code_d = 2'd0;  // A a
         DATA_WIDTH'(8'h43), DATA_WIDTH'(8'h63): code_d = 2'd1;  // C c
         DATA_WIDTH'(8'h47), DATA_WIDTH'(8'h67): code_d = 2'd2;  // G g
         DATA_WIDTH'(8'h54), DATA_WIDTH'(8'h74): code_d = 2'd3;  // T t
         default:                                invalid_d = 1'b1;
      endcase
   end

   // NOTE: all state uses non-blocking assignments. Each register then sees
   // the values from before the edge, whatever order the statements are in.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rd_ptr_q    <= '0;
         remaining_q <= '0;
         issue_idx_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         m_valid_q   <= 1'b0;
         m_char_q    <= '0;
         m_code_q    <= 2'd0;
         m_invalid_q <= 1'b0;
         m_index_q   <= '0;
         m_last_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  rd_ptr_q    <= base_addr[AW-1:0];
                  remaining_q <= len_clamp_d;
                  issue_idx_q <= '0;
                  busy_q      <= 1'b1;
                  state_q     <= S_STREAM;
               end
            end
            S_STREAM: begin
               if (remaining_q == '0) begin
                  // A zero-length command issues nothing. It passes through
                  // here for one cycle, so done comes two cycles after start.
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else if (load_d) begin
                  m_valid_q   <= 1'b1;
                  m_char_q    <= char_d;
                  m_code_q    <= code_d;
                  m_invalid_q <= invalid_d;
                  m_index_q   <= issue_idx_q;
                  m_last_q    <= (remaining_q == LEN_WIDTH'(1));
                  rd_ptr_q    <= rd_ptr_q + AW'(1);
                  issue_idx_q <= issue_idx_q + LEN_WIDTH'(1);
                  remaining_q <= remaining_q - LEN_WIDTH'(1);
                  if (remaining_q == LEN_WIDTH'(1)) begin
                     state_q <= S_FLUSH;
                  end
               end
            end
            S_FLUSH: begin
               if (m_valid_q && m_ready && m_last_q) begin
                  m_valid_q <= 1'b0;
                  done_q    <= 1'b1;
                  state_q   <= S_DONE;
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign r_addr    = {{(32-AW){1'b0}}, rd_ptr_q};
   assign busy      = busy_q;
   assign done      = done_q;
   assign m_valid   = m_valid_q;
   assign m_char    = m_char_q;
   assign m_code    = m_code_q;
   assign m_invalid = m_invalid_q;
   assign m_index   = m_index_q;
   assign m_last    = m_last_q;

endmodule
